ad9361_spi_seq: RTL and testbench

Command sequencer and arbiter in front of the AD9361 SPI master. It walks an external command table (writes, read-poll-until-match, delays, end) to bring the transceiver up after reset. Once the table finishes, it grants single register reads and writes from a user port. It is the only block that drives the SPI master's wr_req/rd_req.

---
 rtl/ad9361_spi_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_ad9361_spi_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_spi_seq.sv
// AD9361 SPI command sequencer: walks the init command table, then arbitrates user register access.
// Optional build macro SEQ_WR_VERIFY_EN: read back every table WRITE and flag a mismatch as an error.
module ad9361_spi_seq #(
    parameter int unsigned CMD_AW   = 8,
    parameter logic [15:0] POLL_MAX = 16'd1000,
    parameter logic [15:0] DLY_UNIT = 16'd1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              init_done,
    output logic              init_err,
    output logic [CMD_AW-1:0] err_idx,
    output logic [CMD_AW-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic              usr_wr_req,
    input  logic              usr_rd_req,
    input  logic [9:0]        usr_addr,
    input  logic [7:0]        usr_wdata,
    output logic [7:0]        usr_rdata,
    output logic              usr_ack,
    output logic              spi_wr_req,
    input  logic              spi_wr_end,
    output logic              spi_rd_req,
    input  logic              spi_rd_end,
    output logic [9:0]        spi_addr,
    output logic [7:0]        spi_wdata,
    input  logic [7:0]        spi_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_WR_WAIT, S_RD_WAIT,
        S_CHECK, S_DELAY, S_USR_WAIT, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;

    state_t            state_q, state_nxt;
    logic [CMD_AW-1:0] cmd_addr_nxt, err_idx_nxt;
    logic              busy_nxt, init_done_nxt, init_err_nxt;
    logic              spi_wr_req_nxt, spi_rd_req_nxt, usr_ack_nxt;
    logic [9:0]        spi_addr_nxt;
    logic [7:0]        spi_wdata_nxt, usr_rdata_nxt;
    logic [15:0]       poll_cnt_q, poll_cnt_nxt, poll_cnt_inc;
    logic [35:0]       dly_cnt_q, dly_cnt_nxt, dly_total;
    logic              usr_wr_q, usr_wr_nxt;
    logic [31:0]       cmd_q, cmd_nxt;
    logic [7:0]        rdata_q, rdata_nxt;
    logic              advance, fail;
`ifdef SEQ_WR_VERIFY_EN
    logic              vfy_q, vfy_nxt;
`endif

    function automatic logic masked_eq(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] m);
        return ((a ^ b) & m) == 8'h00;
    endfunction

    assign dly_total    = 36'(cmd_q[19:0]) * 36'(DLY_UNIT);
    assign poll_cnt_inc = poll_cnt_q + 16'd1;

    always_comb begin
        state_nxt      = state_q;
        cmd_addr_nxt   = cmd_addr;
        err_idx_nxt    = err_idx;
        busy_nxt       = busy;
        init_done_nxt  = init_done;
        init_err_nxt   = init_err;
        spi_wr_req_nxt = 1'b0;
        spi_rd_req_nxt = 1'b0;
        spi_addr_nxt   = spi_addr;
        spi_wdata_nxt  = spi_wdata;
        usr_rdata_nxt  = usr_rdata;
        usr_ack_nxt    = 1'b0;
        poll_cnt_nxt   = poll_cnt_q;
        dly_cnt_nxt    = dly_cnt_q;
        usr_wr_nxt     = usr_wr_q;
        cmd_nxt        = cmd_q;
        rdata_nxt      = rdata_q;
        advance        = 1'b0;
        fail           = 1'b0;
`ifdef SEQ_WR_VERIFY_EN
        vfy_nxt        = vfy_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cmd_addr_nxt  = '0;
                    busy_nxt      = 1'b1;
                    init_done_nxt = 1'b0;
                    init_err_nxt  = 1'b0;
                    state_nxt     = S_FETCH;
                end else if (init_done && !usr_ack && (usr_wr_req || usr_rd_req)) begin
                    // usr_ack gating stops a requester that is still dropping its level from being re-served
                    usr_wr_nxt     = usr_wr_req;
                    spi_wr_req_nxt = usr_wr_req;
                    spi_rd_req_nxt = !usr_wr_req;
                    spi_addr_nxt   = usr_addr;
                    spi_wdata_nxt  = usr_wdata;
                    state_nxt      = S_USR_WAIT;
                end
            end
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: begin
                cmd_nxt   = cmd_data;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (cmd_q[31:30])
                    OP_WRITE: begin
                        spi_wr_req_nxt = 1'b1;
                        spi_addr_nxt   = cmd_q[29:20];
                        spi_wdata_nxt  = cmd_q[19:12];
                        state_nxt      = S_WR_WAIT;
                    end
                    OP_POLL: begin
                        poll_cnt_nxt   = 16'd0;
                        spi_rd_req_nxt = 1'b1;
                        spi_addr_nxt   = cmd_q[29:20];
                        state_nxt      = S_RD_WAIT;
`ifdef SEQ_WR_VERIFY_EN
                        vfy_nxt        = 1'b0;
`endif
                    end
                    OP_DELAY: begin
                        if (dly_total == 36'd0) begin
                            advance = 1'b1;
                        end else begin
                            dly_cnt_nxt = dly_total;
                            state_nxt   = S_DELAY;
                        end
                    end
                    default: begin
                        init_done_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                        state_nxt     = S_DONE;
                    end
                endcase
            end
            S_WR_WAIT: begin
                if (spi_wr_end) begin
`ifdef SEQ_WR_VERIFY_EN
                    spi_rd_req_nxt = 1'b1;
                    vfy_nxt        = 1'b1;
                    state_nxt      = S_RD_WAIT;
`else
                    advance = 1'b1;
`endif
                end
            end
            S_RD_WAIT: begin
                if (spi_rd_end) begin
                    rdata_nxt = spi_rdata;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef SEQ_WR_VERIFY_EN
                if (vfy_q) begin
                    if (rdata_q == cmd_q[19:12]) advance = 1'b1;
                    else                         fail    = 1'b1;
                end else
`endif
                if (masked_eq(rdata_q, cmd_q[19:12], cmd_q[11:4])) begin
                    advance = 1'b1;
                end else if (poll_cnt_inc == POLL_MAX) begin
                    fail = 1'b1;
                end else begin
                    poll_cnt_nxt   = poll_cnt_inc;
                    spi_rd_req_nxt = 1'b1;
                    state_nxt      = S_RD_WAIT;
                end
            end
            S_DELAY: begin
                if (dly_cnt_q == 36'd1) advance = 1'b1;
                else                    dly_cnt_nxt = dly_cnt_q - 36'd1;
            end
            S_USR_WAIT: begin
                if (usr_wr_q ? spi_wr_end : spi_rd_end) begin
                    usr_ack_nxt = 1'b1;
                    if (!usr_wr_q) usr_rdata_nxt = spi_rdata;
                    state_nxt = S_DONE;
                end
            end
            S_ERR: begin
                init_err_nxt = 1'b1;
                err_idx_nxt  = cmd_addr;
                busy_nxt     = 1'b0;
                state_nxt    = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Stepping past the last table entry is an error; cmd_addr keeps the last index
        if (advance) begin
            if (&cmd_addr) begin
                fail = 1'b1;
            end else begin
                cmd_addr_nxt = cmd_addr + 1'b1;
                state_nxt    = S_FETCH;
            end
        end
        if (fail) state_nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_addr   <= '0;
            err_idx    <= '0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            init_err   <= 1'b0;
            spi_wr_req <= 1'b0;
            spi_rd_req <= 1'b0;
            spi_addr   <= '0;
            spi_wdata  <= '0;
            usr_rdata  <= '0;
            usr_ack    <= 1'b0;
            poll_cnt_q <= '0;
            dly_cnt_q  <= '0;
            usr_wr_q   <= 1'b0;
`ifdef SEQ_WR_VERIFY_EN
            vfy_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_nxt;
            cmd_addr   <= cmd_addr_nxt;
            err_idx    <= err_idx_nxt;
            busy       <= busy_nxt;
            init_done  <= init_done_nxt;
            init_err   <= init_err_nxt;
            spi_wr_req <= spi_wr_req_nxt;
            spi_rd_req <= spi_rd_req_nxt;
            spi_addr   <= spi_addr_nxt;
            spi_wdata  <= spi_wdata_nxt;
            usr_rdata  <= usr_rdata_nxt;
            usr_ack    <= usr_ack_nxt;
            poll_cnt_q <= poll_cnt_nxt;
            dly_cnt_q  <= dly_cnt_nxt;
            usr_wr_q   <= usr_wr_nxt;
`ifdef SEQ_WR_VERIFY_EN
            vfy_q      <= vfy_nxt;
`endif
        end
    end

    // Command word and read capture are pure data; state qualifies every use
    always_ff @(posedge clk) begin
        cmd_q   <= cmd_nxt;
        rdata_q <= rdata_nxt;
    end

endmodule

// File: tb/tb_ad9361_spi_seq.sv
// Scoreboard bench for ad9361_spi_seq: command table ROM, SPI master model, event monitor.
module tb_ad9361_spi_seq;

    localparam int K_WR = 0, K_RD = 1, K_ACK = 2;
    localparam logic [1:0] OP_W = 2'b00, OP_P = 2'b01, OP_E = 2'b11;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        busy, init_done, init_err;
    logic [3:0]  err_idx, cmd_addr;
    logic [31:0] cmd_data = 32'h0;
    logic        usr_wr_req = 1'b0, usr_rd_req = 1'b0;
    logic [9:0]  usr_addr = 10'h0;
    logic [7:0]  usr_wdata = 8'h0, usr_rdata;
    logic        usr_ack, spi_wr_req, spi_rd_req;
    logic        spi_wr_end, spi_rd_end;
    logic [9:0]  spi_addr;
    logic [7:0]  spi_wdata, spi_rdata;

    ad9361_spi_seq #(.CMD_AW(4), .POLL_MAX(16'd5), .DLY_UNIT(16'd10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .init_done(init_done),
        .init_err(init_err), .err_idx(err_idx), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .usr_wr_req(usr_wr_req), .usr_rd_req(usr_rd_req), .usr_addr(usr_addr),
        .usr_wdata(usr_wdata), .usr_rdata(usr_rdata), .usr_ack(usr_ack),
        .spi_wr_req(spi_wr_req), .spi_wr_end(spi_wr_end), .spi_rd_req(spi_rd_req),
        .spi_rd_end(spi_rd_end), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_rdata(spi_rdata)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0, ev_cnt = 0;

    typedef struct { int kind; logic [9:0] addr; logic [7:0] data; } exp_t;
    exp_t exp_q[$];
    logic [7:0] rd_resp[$];
    logic [31:0] table_mem [16];

    always @(posedge clk) cmd_data <= table_mem[cmd_addr];

    // SPI master model: fixed latency, flags overlap and unstable addr/data
    logic       act = 1'b0, pend_wr = 1'b0, proto_err = 1'b0;
    logic [2:0] lcnt = 3'd0;
    logic [9:0] lat_addr = 10'h0;
    logic [7:0] lat_wdata = 8'h0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_wr_end <= 1'b0; spi_rd_end <= 1'b0; spi_rdata <= 8'h00;
            act <= 1'b0; lcnt <= 3'd0;
        end else begin
            spi_wr_end <= 1'b0;
            spi_rd_end <= 1'b0;
            if (spi_wr_req || spi_rd_req) begin
                if (act) proto_err <= 1'b1;
                act <= 1'b1; lcnt <= 3'd3; pend_wr <= spi_wr_req;
                lat_addr <= spi_addr; lat_wdata <= spi_wdata;
            end else if (act) begin
                if (spi_addr != lat_addr || (pend_wr && spi_wdata != lat_wdata)) proto_err <= 1'b1;
                if (lcnt == 3'd1) begin
                    act <= 1'b0;
                    if (pend_wr) spi_wr_end <= 1'b1;
                    else begin
                        spi_rd_end <= 1'b1;
                        spi_rdata  <= (rd_resp.size() > 0) ? rd_resp.pop_front() : 8'h00;
                    end
                end else lcnt <= lcnt - 3'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act_v, exp_v);
        end
    endtask

    task automatic push(input int kind, input logic [9:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input int kind, input logic [9:0] a, input logic [7:0] d);
        exp_t e;
        ev_cnt++;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected event kind=%0d addr=%0h data=%0h, none required", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != a || e.data != d) begin
                bad++;
                $display("FAIL event: got kind=%0d addr=%0h data=%0h want kind=%0d addr=%0h data=%0h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (spi_wr_req && spi_rd_req) check("wr_rd_together", 32'd1, 32'd0);
            if (spi_wr_req) mon_event(K_WR, spi_addr, spi_wdata);
            if (spi_rd_req) mon_event(K_RD, spi_addr, 8'h00);
            if (usr_ack)    mon_event(K_ACK, 10'h000, usr_rdata);
        end
    end

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [9:0] a,
                                       input logic [7:0] d, input logic [7:0] m);
        return {op, a, d, m, 4'h0};
    endfunction

    function automatic logic [31:0] mk_dly(input logic [19:0] ticks);
        return {2'b10, 10'h000, ticks};
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 16; i++) table_mem[i] = mk(OP_E, 10'h0, 8'h0, 8'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // which: 0 spi_wr_req, 1 spi_wr_end, 2 busy low, 3 usr_ack
    task automatic wait_evt(input int which, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && spi_wr_req) || (which == 1 && spi_wr_end) ||
                (which == 2 && !busy) || (which == 3 && usr_ack)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++; bad++;
            $display("FAIL timeout waiting for event %0d", which);
        end
    endtask

    initial begin
        int t0, t1, t2, t3, t4, ev0;
        clear_table();
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({busy, init_done, init_err, err_idx, cmd_addr, usr_ack,
                              spi_wr_req, spi_rd_req}), 32'd0);
        check("rst_data", 32'({usr_rdata, spi_addr, spi_wdata}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // user requests before init_done get no service
        ev0 = ev_cnt;
        usr_rd_req = 1'b1; usr_addr = 10'h037;
        repeat (20) @(negedge clk);
        check("usr_blocked_pre_init", 32'(ev_cnt), 32'(ev0));
        usr_rd_req = 1'b0;

        // single WRITE then END
        table_mem[0] = mk(OP_W, 10'h3DF, 8'h01, 8'h00);
        push(K_WR, 10'h3DF, 8'h01);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_evt(1, 200, t0);
        wait_evt(2, 200, t1);
        check("init_done_latency", 32'(t1 - t0), 32'd4);
        check("t1_status", 32'({init_done, init_err, busy}), 32'b100);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // POLL matching on the fourth read
        clear_table();
        table_mem[0] = mk(OP_P, 10'h247, 8'h02, 8'h02);
        rd_resp = '{8'h00, 8'h00, 8'h00, 8'h02};
        for (int i = 0; i < 4; i++) push(K_RD, 10'h247, 8'h00);
        pulse_start();
        wait_evt(2, 500, t0);
        check("poll_ok_status", 32'({init_done, init_err}), 32'b10);
        check("poll_ok_q_empty", 32'(exp_q.size()), 32'd0);

        // POLL that never matches, at table index 1
        clear_table();
        table_mem[0] = mk(OP_W, 10'h001, 8'h55, 8'h00);
        table_mem[1] = mk(OP_P, 10'h010, 8'h80, 8'h80);
        push(K_WR, 10'h001, 8'h55);
        for (int i = 0; i < 5; i++) push(K_RD, 10'h010, 8'h00);
        pulse_start();
        wait_evt(2, 500, t0);
        check("poll_fail_status", 32'({init_done, init_err}), 32'b01);
        check("poll_fail_err_idx", 32'(err_idx), 32'd1);
        check("poll_fail_q_empty", 32'(exp_q.size()), 32'd0);
        ev0 = ev_cnt;
        usr_wr_req = 1'b1; usr_addr = 10'h020; usr_wdata = 8'h11;
        repeat (20) @(negedge clk);
        check("usr_blocked_after_err", 32'(ev_cnt), 32'(ev0));
        usr_wr_req = 1'b0;

        // DELAY 3 ticks (30 cycles) then DELAY 0
        clear_table();
        table_mem[0] = mk(OP_W, 10'h100, 8'hAA, 8'h00);
        table_mem[1] = mk_dly(20'd3);
        table_mem[2] = mk(OP_W, 10'h101, 8'hBB, 8'h00);
        table_mem[3] = mk_dly(20'd0);
        table_mem[4] = mk(OP_W, 10'h102, 8'hCC, 8'h00);
        push(K_WR, 10'h100, 8'hAA); push(K_WR, 10'h101, 8'hBB); push(K_WR, 10'h102, 8'hCC);
        pulse_start();
        wait_evt(0, 200, t0);
        wait_evt(1, 200, t1);
        wait_evt(0, 200, t2);
        check("delay3_gap", 32'(t2 - t1), 32'd37);
        wait_evt(1, 200, t3);
        wait_evt(0, 200, t4);
        check("delay0_gap", 32'(t4 - t3), 32'd7);
        wait_evt(2, 200, t0);
        check("delay_done", 32'({init_done, init_err}), 32'b10);

        // user read, then simultaneous write+read
        rd_resp.push_back(8'hA5);
        push(K_RD, 10'h037, 8'h00); push(K_ACK, 10'h000, 8'hA5);
        usr_rd_req = 1'b1; usr_addr = 10'h037;
        wait_evt(3, 200, t0);
        usr_rd_req = 1'b0;
        check("usr_rdata", 32'(usr_rdata), 32'h0A5);
        @(negedge clk);
        check("usr_ack_one_cycle", 32'(usr_ack), 32'd0);
        rd_resp.push_back(8'h5A);
        push(K_WR, 10'h055, 8'h3C); push(K_ACK, 10'h000, 8'hA5);
        push(K_RD, 10'h055, 8'h00); push(K_ACK, 10'h000, 8'h5A);
        usr_addr = 10'h055; usr_wdata = 8'h3C;
        usr_wr_req = 1'b1; usr_rd_req = 1'b1;
        wait_evt(3, 200, t0);
        usr_wr_req = 1'b0;
        wait_evt(3, 200, t0);
        usr_rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("usr_q_empty", 32'(exp_q.size()), 32'd0);

        // table wrap past last entry; start while busy is ignored
        for (int i = 0; i < 16; i++) begin
            table_mem[i] = mk(OP_W, 10'(i + 'h200), 8'(i + 1), 8'h00);
            push(K_WR, 10'(i + 'h200), 8'(i + 1));
        end
        pulse_start();
        wait_evt(0, 200, t0);
        wait_evt(0, 200, t0);
        pulse_start();
        wait_evt(2, 2000, t0);
        check("wrap_status", 32'({init_done, init_err}), 32'b01);
        check("wrap_err_idx", 32'(err_idx), 32'd15);
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // reset in WR_WAIT, then rerun from entry 0
        clear_table();
        table_mem[0] = mk(OP_W, 10'h3DF, 8'h01, 8'h00);
        push(K_WR, 10'h3DF, 8'h01);
        pulse_start();
        wait_evt(0, 200, t0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ctl", 32'({busy, init_done, init_err, err_idx, cmd_addr, usr_ack,
                                    spi_wr_req, spi_rd_req}), 32'd0);
        check("async_rst_data", 32'({usr_rdata, spi_addr, spi_wdata}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        push(K_WR, 10'h3DF, 8'h01);
        pulse_start();
        wait_evt(2, 200, t0);
        check("rerun_status", 32'({init_done, init_err}), 32'b10);
        check("rerun_q_empty", 32'(exp_q.size()), 32'd0);
        check("spi_protocol", 32'(proto_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
